regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 two-read/one-write register file among N_REQ requesters, e.g. a load-return unit, an ALU writeback and a debug/initialisation loader.
- Round-robin arbitration with a per-requester valid/ready handshake.
- A requester may lock the port for a bounded burst of back-to-back writes.
- The output stage is registered and drives the register file's write, wrAddr and wrData inputs directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- BURST_MAX, 4, maximum beats per locked burst (>=1).
- DROP_R0, 0, if 1, writes to address 0 are accepted but never strobed.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- hold  in  1  freeze arbitration; no new handshakes while high.
- req_valid  in  N_REQ  requester i has a write pending.
- req_lock  in  N_REQ  requester i requests to keep ownership after this beat.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed data; slice i = [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot or zero; the beat transfers when valid[i] & ready[i].
- write  out  1  register-file write strobe (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- grant_id  out  clog2(N_REQ)  index of the last accepted requester (registered).
- busy  out  1  high while in LOCKED state.

Behaviour:
- Reset values: write=0, wr_addr=0, wr_data=0, grant_id=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0. req_ready=0 while rst_n=0.
- req_ready is combinational from state, rr_ptr, req_valid and hold. At most one bit is high; all bits are 0 when hold=1.
- IDLE state:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ. Only the winner's req_ready is high.
  - On handshake: rr_ptr <= winner+1 (mod N_REQ).
  - If req_lock[winner]=1 and BURST_MAX>1: go to LOCKED, owner <= winner, beat_cnt <= 1. Otherwise stay in IDLE.
- LOCKED state:
  - req_ready[owner] = ~hold; all other ready bits are 0, even if their valid is high.
  - Each owner handshake increments beat_cnt.
  - Return to IDLE on the first of:
    - a handshake with req_lock[owner]=0;
    - a handshake that makes beat_cnt reach BURST_MAX;
    - a cycle with req_valid[owner]=0 and req_lock[owner]=0 (abandon, no write).
  - If owner keeps lock=1 with valid=0, the port idles in LOCKED. This is a permitted stall; others stay blocked.
  - rr_ptr stays at owner+1 throughout LOCKED.
- Output stage, evaluated every cycle:
  - write <= handshake & ~(DROP_R0 & addr==0).
  - On handshake: wr_addr/wr_data <= the winner's slices and grant_id <= winner. Otherwise wr_addr, wr_data and grant_id hold their values.
- Latency: exactly 1 cycle from handshake to write=1. The register file commits on the following edge. Sustained throughput is 1 write per cycle.
- hold=1: no handshake; state, rr_ptr and beat_cnt are held; write=0 on the next cycle. Releasing hold resumes with the same priority.
- Simultaneous valid from all requesters in IDLE: strict rotation; each requester gets one beat per N_REQ cycles.
- Mid-operation reset: everything returns to reset values immediately. A beat that is registered but not yet strobed is lost.
- busy = (state==LOCKED), registered.

Decomposition:
- Shared package regfile_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32, and the state encoding (ARB_IDLE, ARB_LOCKED).
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are req vector and pointer; outputs are a one-hot grant and its index. Reusable for a future read-port arbiter.

Test Plan:
- Reset: rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0, write=0, wr_addr=0, busy=0. Release rst_n -> requester 0 is granted first, and write=1 one cycle later.
- Single requester: req 2 writes addr i, data i*11111 for i=0..31 -> write=1 on each following cycle with matching wr_addr/wr_data; grant_id=2; no gaps.
- Contention: all 4 valid, lock=0, 8 cycles -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready high per cycle.
- Burst: req 1 lock=1 for 6 beats, BURST_MAX=4, req 3 also valid -> 4 beats from req 1, busy=1 during the burst, then req 3 is granted, then req 1 resumes.
- Hold: assert hold mid-burst for 3 cycles -> req_ready=0 and write=0 for those cycles (write low one cycle delayed); beat_cnt preserved; the burst completes its remaining beats afterwards.
- DROP_R0=1: req 0 writes addr 0 data 32'hDEADBEEF -> handshake completes, write stays 0; next beat to addr 5 strobes normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
// Imported by the write-port arbiter and its round-robin picker.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arbState_t;

    // Index width for an N-entry vector, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Returns a one-hot grant and its index; all zero when nothing is requested.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idxWidth(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx
);

    // Scan from the farthest candidate back to ptr so the nearest one wins last.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant                         = '0;
                grant[(int'(ptr) + k) % N]    = 1'b1;
                grantIdx                      = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with
// bounded locked bursts and a registered write stage.
//
// state      | meaning
// ARB_IDLE   | round-robin among all valid requesters, one beat per grant
// ARB_LOCKED | owner keeps the port for up to BURST_MAX back-to-back beats
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int BURST_MAX = 4,
    parameter bit DROP_R0   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      write,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arbState_t        state, stateNext;
    logic [IDX_W-1:0] rrPtr, rrPtrNext;
    logic [IDX_W-1:0] owner, ownerNext;
    logic [IDX_W-1:0] pickIdx, winIdx;
    logic [CNT_W-1:0] beatCnt, beatCntNext, beatInc;
    logic [N_REQ-1:0] pickGrant, readyVec;
    logic             handshake, dropBeat;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) uPick (
        .req      (req_valid),
        .ptr      (rrPtr),
        .grant    (pickGrant),
        .grantIdx (pickIdx)
    );

    // Ready is gated by reset so no requester sees a handshake while rst_n is low.
    always_comb begin
        readyVec = '0;
        if (rst_n && !hold) begin
            if (state == ARB_IDLE) begin
                readyVec = pickGrant;
            end else begin
                readyVec[owner] = 1'b1;
            end
        end
    end

    assign req_ready = readyVec;
    assign winIdx    = (state == ARB_IDLE) ? pickIdx : owner;
    assign handshake = |(req_valid & readyVec);
    assign winAddr   = req_addr[int'(winIdx) * ADDR_W +: ADDR_W];
    assign winData   = req_data[int'(winIdx) * DATA_W +: DATA_W];
    assign dropBeat  = DROP_R0 && (winAddr == '0);

    always_comb begin
        stateNext   = state;
        rrPtrNext   = rrPtr;
        ownerNext   = owner;
        beatCntNext = beatCnt;
        beatInc     = beatCnt + CNT_W'(1);
        case (state)
            ARB_IDLE: begin
                if (handshake) begin
                    rrPtrNext = (winIdx == IDX_W'(N_REQ - 1)) ? '0 : winIdx + IDX_W'(1);
                    if (req_lock[winIdx] && (BURST_MAX > 1)) begin
                        stateNext   = ARB_LOCKED;
                        ownerNext   = winIdx;
                        beatCntNext = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                // rrPtr already points past the owner, so it is left untouched here.
                if (handshake) begin
                    beatCntNext = beatInc;
                    if (!req_lock[owner] || (beatInc == CNT_W'(BURST_MAX))) begin
                        stateNext   = ARB_IDLE;
                        beatCntNext = '0;
                    end
                end else if (!hold && !req_valid[owner] && !req_lock[owner]) begin
                    stateNext   = ARB_IDLE;
                    beatCntNext = '0;
                end
            end
            default: begin
                stateNext   = ARB_IDLE;
                beatCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rrPtr   <= '0;
            owner   <= '0;
            beatCnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= stateNext;
            rrPtr   <= rrPtrNext;
            owner   <= ownerNext;
            beatCnt <= beatCntNext;
            busy    <= (stateNext == ARB_LOCKED);
        end
    end

    // A dropped address-0 beat still completes its handshake; only the strobe is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            write <= handshake && !dropBeat;
            if (handshake) begin
                wr_addr  <= winAddr;
                wr_data  <= winData;
                grant_id <= winIdx;
            end
        end
    end

endmodule
